button_repeat_debouncer: RTL and testbench
==========================================

BUTTON_REPEAT_DEBOUNCER -- requirements
Module: button_repeat_debouncer

Interface
- REQ-001 SHALL have parameter NUM_BUTTONS, default 4: number of independent button channels (1..16).
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000: stable cycles required before a debounced level changes (10 ms at 25 MHz).
- REQ-003 SHALL have parameter REPEAT_DELAY_CYCLES, default 12500000: held cycles from press to first repeat pulse.
- REQ-004 SHALL have parameter REPEAT_RATE_CYCLES, default 2500000: cycles between subsequent repeat pulses.
- REQ-005 SHALL have port i_Clk, input, 1: the single clock. All logic SHALL run on its rising edge.
- REQ-006 SHALL have port i_Reset, input, 1: synchronous, active-high reset.
- REQ-007 SHALL have port i_Buttons, input, NUM_BUTTONS: raw, asynchronous, active-high switches.
- REQ-008 SHALL have port o_Debounced, output, NUM_BUTTONS: debounced levels.
- REQ-009 SHALL have port o_Press_Pulse, output, NUM_BUTTONS: one-cycle pulse on each debounced rise.
- REQ-010 SHALL have port o_Release_Pulse, output, NUM_BUTTONS: one-cycle pulse on each debounced fall.
- REQ-011 SHALL have port o_Repeat_Pulse, output, NUM_BUTTONS: one-cycle auto-repeat pulse while a button is held.
- REQ-012 SHALL have port o_Move_Event, output, NUM_BUTTONS: bitwise OR of o_Press_Pulse and o_Repeat_Pulse.
- REQ-013 SHALL have port o_Chord_Pulse, output, 1: one-cycle pulse when all o_Debounced bits first become 1 together (game start).

Function
- REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
- REQ-015 Debounce behaviour:
  - a per-channel counter of width clog2(DEBOUNCE_CYCLES+1) SHALL clear whenever the synchronized input equals o_Debounced, and increment otherwise;
  - when the counter reaches DEBOUNCE_CYCLES-1, o_Debounced SHALL toggle and the counter SHALL clear.
- REQ-016 An input change held stable SHALL appear on o_Debounced exactly DEBOUNCE_CYCLES+2 cycles after the raw edge is sampled. Any glitch shorter than DEBOUNCE_CYCLES SHALL be fully rejected.
- REQ-017 o_Press_Pulse and o_Release_Pulse SHALL each be high for exactly the first cycle in which o_Debounced shows the new level.
- REQ-018 Each channel SHALL run a repeat FSM with states IDLE, DELAY and REPEAT:
  - IDLE -> DELAY on debounced rise, clearing the repeat counter;
  - DELAY -> REPEAT when the counter reaches REPEAT_DELAY_CYCLES-1, pulsing o_Repeat_Pulse and clearing the counter;
  - REPEAT SHALL pulse o_Repeat_Pulse and clear the counter each time the counter reaches REPEAT_RATE_CYCLES-1;
  - any state -> IDLE in the same cycle o_Debounced falls, with no repeat pulse emitted that cycle.
- REQ-019 Repeat counters SHALL saturate, never wrap, and SHALL be sized clog2 of max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES).
- REQ-020 Channels SHALL be fully independent. Simultaneous presses on several channels SHALL produce pulses on all of them in the same cycle.
- REQ-021 o_Chord_Pulse SHALL be registered:
  - it SHALL pulse in the cycle after the AND of o_Debounced transitions from 0 to 1;
  - it SHALL NOT re-fire until at least one button has been released.
- REQ-022 All outputs SHALL be registered, with no combinational path from i_Buttons to any output.

Reset
- REQ-023 While i_Reset is high at a clock edge, all outputs, synchronizer flops and counters SHALL be 0, and all FSMs SHALL be in IDLE.
- REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort that activity with no pulse emitted.
- REQ-025 After reset, a button already held SHALL be treated as a fresh press: o_Press_Pulse SHALL fire DEBOUNCE_CYCLES+2 cycles after reset deasserts.

Configuration
- REQ-026 With macro BUTTON_AUTO_REPEAT_EN defined, the repeat FSMs and repeat counters SHALL be built as specified.
- REQ-027 Without BUTTON_AUTO_REPEAT_EN, o_Repeat_Pulse SHALL be constant 0, o_Move_Event SHALL equal o_Press_Pulse, and no repeat counters SHALL be synthesized.

Structure
- REQ-028 A shared package button_pkg SHALL hold the repeat FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2) and the default timing constants.
- REQ-029 The per-channel logic (synchronizer, debounce, edge pulses, repeat FSM) SHALL be a sub-module, button_channel, instantiated NUM_BUTTONS times by a generate loop. Chord logic SHALL live in the top.

Verification (bench parameters: NUM_BUTTONS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3, macro defined)
- REQ-030 Raw bit0 rises and stays high -> o_Debounced[0]=1 and o_Press_Pulse[0]=1 for one cycle, 6 cycles after the edge.
- REQ-031 Raw bit1 high for 3 cycles then low -> no change on any bit1 output.
- REQ-032 Bit2 held for 30 cycles after debounce -> o_Repeat_Pulse[2] at +10, +13, +16, ... cycles after the press pulse; release -> o_Release_Pulse[2] and no further repeats.
- REQ-033 All four raw bits rise together -> four press pulses in one cycle, o_Chord_Pulse one cycle later; all held 20 more cycles -> no second chord pulse.
- REQ-034 i_Reset pulsed during DELAY on bit3 while still held -> all outputs 0, no repeat pulse; new o_Press_Pulse[3] 6 cycles after reset deasserts.
- REQ-035 Rebuild without BUTTON_AUTO_REPEAT_EN, bit0 held for 40 cycles -> exactly one o_Move_Event[0] pulse, o_Repeat_Pulse constant 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default timing for the button debounce / auto-repeat block.
// The repeat FSM encoding is fixed here so every channel and any debug tooling agree on it.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEF_NUM_BUTTONS         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 250000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 12500000;
  localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 2500000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_repeat_debouncer_if.sv
// Event bundle produced by a button channel: debounced level plus its one-cycle pulses.
// WIDTH=1 per channel inside the design; wider instances can carry a whole button bank.
interface button_repeat_debouncer_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] rel;
  logic [WIDTH-1:0] rpt;
  logic [WIDTH-1:0] move;

  modport master (output debounced, press, rel, rpt, move);
  modport slave  (input  debounced, press, rel, rpt, move);
endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, stable-count debounce, edge pulses and repeat FSM.
// Auto-repeat logic is only built when BUTTON_AUTO_REPEAT_EN is defined.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             btn_i,
  button_repeat_debouncer_if.master        evt_if
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_timing
    $error("button_channel: timing parameters must be at least 1");
  end

  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_q, deb_d;
  logic             press_q, rel_q, rpt_q, move_q;
  logic             rise_c, fall_c, rpt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      rpt_q     <= 1'b0;
      move_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
      press_q   <= rise_c;
      rel_q     <= fall_c;
      rpt_q     <= rpt_d;
      move_q    <= rise_c | rpt_d;
    end
  end

  // Level flips only after the synchronized input disagrees for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    deb_cnt_d = '0;
    deb_d     = deb_q;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign rise_c = deb_d & ~deb_q;
  assign fall_c = ~deb_d & deb_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = (&rpt_cnt_q) ? rpt_cnt_q : rpt_cnt_q + RPT_W'(1);
    rpt_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (rise_c) state_d = DELAY;
      end
      DELAY: begin
        if (rpt_cnt_q == RPT_W'(REPEAT_DELAY_CYCLES - 1)) begin
          state_d   = REPEAT;
          rpt_d     = 1'b1;
          rpt_cnt_d = '0;
        end
      end
      REPEAT: begin
        if (rpt_cnt_q == RPT_W'(REPEAT_RATE_CYCLES - 1)) begin
          rpt_d     = 1'b1;
          rpt_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A release always wins, suppressing any repeat due in the same cycle.
    if (fall_c) begin
      state_d   = IDLE;
      rpt_d     = 1'b0;
      rpt_cnt_d = '0;
    end
  end
`else
  assign rpt_d = 1'b0;
`endif

  assign evt_if.debounced = deb_q;
  assign evt_if.press     = press_q;
  assign evt_if.rel       = rel_q;
  assign evt_if.rpt       = rpt_q;
  assign evt_if.move      = move_q;

endmodule

// File: rtl/button_repeat_debouncer.sv
// Bank of independent debounced buttons with auto-repeat and an all-buttons chord pulse.
// Auto-repeat is built only with BUTTON_AUTO_REPEAT_EN defined; otherwise move equals press.
module button_repeat_debouncer
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS         = DEF_NUM_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [NUM_BUTTONS-1:0] i_Buttons,
  output logic [NUM_BUTTONS-1:0] o_Debounced,
  output logic [NUM_BUTTONS-1:0] o_Press_Pulse,
  output logic [NUM_BUTTONS-1:0] o_Release_Pulse,
  output logic [NUM_BUTTONS-1:0] o_Repeat_Pulse,
  output logic [NUM_BUTTONS-1:0] o_Move_Event,
  output logic                   o_Chord_Pulse
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_repeat_debouncer_if #(.WIDTH(1)) chan_if ();

    button_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_chan (
      .clk_i  (i_Clk),
      .rst_i  (i_Reset),
      .btn_i  (i_Buttons[g]),
      .evt_if (chan_if.master)
    );

    assign o_Debounced[g]     = chan_if.debounced;
    assign o_Press_Pulse[g]   = chan_if.press;
    assign o_Release_Pulse[g] = chan_if.rel;
    assign o_Repeat_Pulse[g]  = chan_if.rpt;
    assign o_Move_Event[g]    = chan_if.move;
  end

  // Chord fires once per 0->1 transition of the all-pressed condition.
  logic all_c, all_q, chord_q;

  assign all_c = &o_Debounced;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      all_q   <= 1'b0;
      chord_q <= 1'b0;
    end else begin
      all_q   <= all_c;
      chord_q <= all_c & ~all_q;
    end
  end

  assign o_Chord_Pulse = chord_q;

endmodule

// File: tb/tb_button_repeat_debouncer.sv
// Randomized self-checking bench: history-window reference model plus pinned literal expectations.
module tb_button_repeat_debouncer;

  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif
  localparam int K_DEB = 0, K_PRS = 1, K_REL = 2, K_RPT = 3, K_MOV = 4, K_CHD = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic          chord;

  button_repeat_debouncer_if #(.WIDTH(NB)) obs ();

  button_repeat_debouncer #(
    .NUM_BUTTONS         (NB),
    .DEBOUNCE_CYCLES     (DEB),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_RATE_CYCLES  (RR)
  ) dut (
    .i_Clk           (clk),
    .i_Reset         (rst),
    .i_Buttons       (btn),
    .o_Debounced     (obs.debounced),
    .o_Press_Pulse   (obs.press),
    .o_Release_Pulse (obs.rel),
    .o_Repeat_Pulse  (obs.rpt),
    .o_Move_Event    (obs.move),
    .o_Chord_Pulse   (chord)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: sample histories, time of last level change, press time.
  logic          smp [NB][64];
  logic          zh  [NB][64];
  int            last [NB];
  int            tp   [NB];
  logic [NB-1:0] mdeb = '0;
  logic          and1 = 1'b0, and2 = 1'b0;
  logic [NB-1:0] exp_deb = '0, exp_prs = '0, exp_rel = '0, exp_rpt = '0, exp_mov = '0;
  logic          exp_chd = 1'b0;

  // Literal expectations scheduled by the stimulus, checked at the named cycle.
  int            n_lit = 0;
  int            l_cyc  [128];
  int            l_kind [128];
  logic [NB-1:0] l_mask [128];
  logic [NB-1:0] l_val  [128];

  always @(posedge clk) begin
    int i, ip;
    logic old, flip;
    cyc = cyc + 1;
    i   = cyc % 64;
    ip  = (cyc - 1) % 64;
    if (rst) begin
      for (int ch = 0; ch < NB; ch++) begin
        smp[ch][i] = 1'b0;
        zh[ch][i]  = 1'b0;
        last[ch]   = cyc;
        tp[ch]     = -1;
      end
      mdeb = '0; exp_deb = '0; exp_prs = '0; exp_rel = '0; exp_rpt = '0; exp_mov = '0;
      exp_chd = 1'b0; and1 = 1'b0; and2 = 1'b0;
    end else begin
      exp_chd = and1 & ~and2;
      and2    = and1;
      for (int ch = 0; ch < NB; ch++) begin
        zh[ch][i]  = smp[ch][ip];
        smp[ch][i] = btn[ch];
        old  = mdeb[ch];
        flip = ((cyc - last[ch]) >= DEB);
        for (int k = 1; k <= DEB; k++)
          if (zh[ch][(cyc - k) % 64] == old) flip = 1'b0;
        if (flip) begin
          mdeb[ch] = ~old;
          last[ch] = cyc;
        end
        exp_prs[ch] = flip & ~old;
        exp_rel[ch] = flip & old;
        if (exp_prs[ch]) tp[ch] = cyc;
        if (exp_rel[ch]) tp[ch] = -1;
        exp_rpt[ch] = RPT_EN && (tp[ch] >= 0) && mdeb[ch] && ((cyc - tp[ch]) >= RD)
                      && (((cyc - tp[ch] - RD) % RR) == 0);
      end
      exp_deb = mdeb;
      exp_mov = exp_prs | exp_rpt;
      and1    = &mdeb;
    end
  end

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [NB-1:0] got;
    if (cyc >= 1) begin
      chk("debounced", obs.debounced, exp_deb);
      chk("press",     obs.press,     exp_prs);
      chk("release",   obs.rel,       exp_rel);
      chk("repeat",    obs.rpt,       exp_rpt);
      chk("move",      obs.move,      exp_mov);
      chk("chord",     {3'b000, chord}, {3'b000, exp_chd});
      for (int n = 0; n < n_lit; n++) begin
        if (l_cyc[n] == cyc) begin
          case (l_kind[n])
            K_DEB:   got = obs.debounced;
            K_PRS:   got = obs.press;
            K_REL:   got = obs.rel;
            K_RPT:   got = obs.rpt;
            K_MOV:   got = obs.move;
            default: got = {3'b000, chord};
          endcase
          chk($sformatf("lit%0d_kind%0d", n, l_kind[n]), got & l_mask[n], l_val[n] & l_mask[n]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input int c, input int k, input logic [NB-1:0] m, input logic [NB-1:0] v);
    l_cyc[n_lit]  = c;
    l_kind[n_lit] = k;
    l_mask[n_lit] = m;
    l_val[n_lit]  = v;
    n_lit++;
  endtask

  initial begin
    int t, tpr, r;
    int hold [NB];
    for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
    rst = 1'b1;
    btn = '0;
    step(3);
    lit(cyc, K_DEB, 4'hF, 4'h0);
    lit(cyc, K_PRS, 4'hF, 4'h0);
    lit(cyc, K_CHD, 4'h1, 4'h0);
    rst = 1'b0;
    step(2);

    // Clean press on bit0: visible DEB+2 cycles after the drive.
    t = cyc; btn[0] = 1'b1;
    lit(t + 5, K_DEB, 4'h1, 4'h0);
    lit(t + 6, K_DEB, 4'h1, 4'h1);
    lit(t + 6, K_PRS, 4'h1, 4'h1);
    lit(t + 6, K_MOV, 4'h1, 4'h1);
    lit(t + 7, K_PRS, 4'h1, 4'h0);
    step(12);

    // Three-cycle glitch on bit1 is rejected.
    t = cyc; btn[1] = 1'b1;
    step(3); btn[1] = 1'b0;
    lit(t + 6, K_DEB, 4'h2, 4'h0);
    lit(t + 6, K_PRS, 4'h2, 4'h0);
    lit(t + 9, K_REL, 4'h2, 4'h0);
    step(12);

    // Bit2 held: repeats at +10, +13, +16 after the press, none after release.
    t = cyc; btn[2] = 1'b1; tpr = t + 6;
    lit(tpr,      K_PRS, 4'h4, 4'h4);
    lit(tpr + 9,  K_RPT, 4'h4, 4'h0);
    lit(tpr + 10, K_RPT, 4'h4, {1'b0, RPT_EN, 2'b00});
    lit(tpr + 11, K_RPT, 4'h4, 4'h0);
    lit(tpr + 13, K_RPT, 4'h4, {1'b0, RPT_EN, 2'b00});
    lit(tpr + 16, K_RPT, 4'h4, {1'b0, RPT_EN, 2'b00});
    step(36); btn[2] = 1'b0;
    lit(t + 42, K_REL, 4'h4, 4'h4);
    lit(t + 42, K_DEB, 4'h4, 4'h0);
    lit(t + 43, K_RPT, 4'h4, 4'h0);
    lit(t + 46, K_RPT, 4'h4, 4'h0);
    step(14); btn[0] = 1'b0;
    step(12);

    // All four together: simultaneous presses, one chord pulse only.
    t = cyc; btn = 4'hF;
    lit(t + 6,  K_PRS, 4'hF, 4'hF);
    lit(t + 6,  K_CHD, 4'h1, 4'h0);
    lit(t + 7,  K_CHD, 4'h1, 4'h1);
    lit(t + 8,  K_CHD, 4'h1, 4'h0);
    lit(t + 17, K_CHD, 4'h1, 4'h0);
    lit(t + 27, K_CHD, 4'h1, 4'h0);
    step(28); btn = '0;
    step(12);

    // Reset during DELAY on bit3 while held: no repeat, fresh press afterwards.
    t = cyc; btn[3] = 1'b1; tpr = t + 6;
    lit(tpr, K_PRS, 4'h8, 4'h8);
    step(11); rst = 1'b1;
    step(1); r = cyc; rst = 1'b0;
    lit(r,      K_DEB, 4'hF, 4'h0);
    lit(r,      K_RPT, 4'hF, 4'h0);
    lit(r + 4,  K_RPT, 4'h8, 4'h0);
    lit(r + 4,  K_DEB, 4'h8, 4'h0);
    lit(r + 5,  K_PRS, 4'h8, 4'h0);
    lit(r + 6,  K_PRS, 4'h8, 4'h8);
    lit(r + 16, K_RPT, 4'h8, {RPT_EN, 3'b000});
    step(20); btn = '0;
    step(12);

    // Bit0 held 40 cycles: move events follow press and (if built) repeats.
    t = cyc; btn[0] = 1'b1; tpr = t + 6;
    lit(tpr,      K_MOV, 4'h1, 4'h1);
    lit(tpr + 1,  K_MOV, 4'h1, 4'h0);
    lit(tpr + 10, K_MOV, 4'h1, {3'b000, RPT_EN});
    lit(tpr + 10, K_RPT, 4'h1, {3'b000, RPT_EN});
    lit(tpr + 20, K_RPT, 4'h1, 4'h0);
    step(46); btn = '0;
    step(12);

    // Random glitches, holds, chords and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        btn = '1;
        for (int ch = 0; ch < NB; ch++) hold[ch] = int'($urandom_range(8, 30));
      end
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          btn[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 12));
        end else begin
          hold[ch] = hold[ch] - 1;
        end
      end
      step(1);
    end
    rst = 1'b0;
    btn = '0;
    step(12);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
